frg_eval_pipe: RTL

- Parametrised, pipelined successor of the flat frg-class priority/product-grid decoder.
- Generalises the fixed 3-row x 2-mode x 2-lane enable/data grid to N_ROW x N_MODE x N_LANE.
- Adds a valid/ready handshake, a 2-stage pipeline with backpressure, and a saturating evaluation counter.
- Sits between the stimulus source and the crossbar result checker in the evaluation flow.

---
 rtl/frg_pkg.sv | 29 ++
 rtl/frg_eval_pipe_if.sv | 44 ++++
 rtl/frg_row_reduce.sv | 25 ++
 rtl/frg_eval_pipe.sv | 96 +++++++++
 4 files changed

// File: rtl/frg_pkg.sv
// Shared constants, grid indexing and the S1 register layout for the frg evaluation pipe.
package frg_pkg;

  localparam int DEF_N_ROW  = 3;
  localparam int DEF_N_MODE = 2;
  localparam int DEF_N_LANE = 2;
  localparam int DEF_CNT_W  = 8;

  // Upper bound on N_ROW so the S1 struct can have a fixed layout; unused bits stay zero.
  localparam int ROW_MAX = 32;

  typedef struct packed {
    logic [ROW_MAX-1:0] row_hit;
    logic               sel;
    logic               a;
    logic               b0;
    logic               b1;
    logic               dflt;
    logic               aux_en;
    logic               aux_n;
    logic               aux2_n;
  } s1_t;

  function automatic int grid_idx(input int r, input int m, input int l,
                                  input int n_mode, input int n_lane);
    return (r * n_mode + m) * n_lane + l;
  endfunction

endpackage

// File: rtl/frg_eval_pipe_if.sv
// Handshake and data bundle between the stimulus source, frg_eval_pipe and the result checker.
interface frg_eval_pipe_if
  import frg_pkg::*;
#(
  parameter int N_ROW  = DEF_N_ROW,
  parameter int N_MODE = DEF_N_MODE,
  parameter int N_LANE = DEF_N_LANE,
  parameter int CNT_W  = DEF_CNT_W
) ();

  logic                            in_valid;
  logic                            in_ready;
  logic                            sel;
  logic                            a;
  logic                            b0;
  logic                            b1;
  logic                            dflt;
  logic [N_ROW-1:0]                row_en;
  logic [N_MODE-1:0]               mode_en;
  logic [N_LANE-1:0]               lane_en;
  logic [N_ROW*N_MODE*N_LANE-1:0]  data;
  logic                            aux_en;
  logic                            aux_n;
  logic                            aux2_n;
  logic                            out_valid;
  logic                            out_ready;
  logic                            f0;
  logic                            f1;
  logic                            f2;
  logic [CNT_W-1:0]                eval_count;

  modport master (
    output in_valid, sel, a, b0, b1, dflt, row_en, mode_en, lane_en, data,
           aux_en, aux_n, aux2_n, out_ready,
    input  in_ready, out_valid, f0, f1, f2, eval_count
  );

  modport slave (
    input  in_valid, sel, a, b0, b1, dflt, row_en, mode_en, lane_en, data,
           aux_en, aux_n, aux2_n, out_ready,
    output in_ready, out_valid, f0, f1, f2, eval_count
  );

endinterface

// File: rtl/frg_row_reduce.sv
// Combinational hit reduction for one grid row: OR over mode/lane of enables AND data.
module frg_row_reduce
  import frg_pkg::*;
#(
  parameter int N_MODE = DEF_N_MODE,
  parameter int N_LANE = DEF_N_LANE
) (
  input  logic                     row_en,
  input  logic [N_MODE-1:0]        mode_en,
  input  logic [N_LANE-1:0]        lane_en,
  input  logic [N_MODE*N_LANE-1:0] row_data,
  output logic                     row_hit
);

  always_comb begin
    row_hit = 1'b0;
    for (int m = 0; m < N_MODE; m++) begin
      for (int l = 0; l < N_LANE; l++) begin
        row_hit = row_hit |
                  (row_en & mode_en[m] & lane_en[l] & row_data[grid_idx(0, m, l, N_MODE, N_LANE)]);
      end
    end
  end

endmodule

// File: rtl/frg_eval_pipe.sv
// Two-stage valid/ready pipeline evaluating the frg priority/product-grid functions.
// f0..f2 come only from S2 registers; eval_count counts output handshakes and saturates.
module frg_eval_pipe
  import frg_pkg::*;
#(
  parameter int N_ROW  = DEF_N_ROW,
  parameter int N_MODE = DEF_N_MODE,
  parameter int N_LANE = DEF_N_LANE,
  parameter int CNT_W  = DEF_CNT_W
) (
  input logic            clk,
  input logic            rst_n,
  frg_eval_pipe_if.slave bus
);

  localparam int ROW_W = N_MODE * N_LANE;

  if (N_ROW < 1 || N_MODE < 1 || N_LANE < 1 || N_ROW > ROW_MAX) begin : g_param_chk
    $error("frg_eval_pipe: N_ROW/N_MODE/N_LANE must be >= 1 and N_ROW <= ROW_MAX");
  end

  logic [N_ROW-1:0] row_hit_c;
  s1_t              s1_d;
  s1_t              s1_q;
  logic             s1_valid;
  logic             s2_valid;
  logic             s2_adv;
  logic             in_acc;
  logic             hit;
  logic             f0_q;
  logic             f1_q;
  logic             f2_q;
  logic [CNT_W-1:0] cnt_q;

  for (genvar r = 0; r < N_ROW; r++) begin : g_row
    localparam int BASE = grid_idx(r, 0, 0, N_MODE, N_LANE);
    frg_row_reduce #(.N_MODE(N_MODE), .N_LANE(N_LANE)) u_row (
      .row_en   (bus.row_en[r]),
      .mode_en  (bus.mode_en),
      .lane_en  (bus.lane_en),
      .row_data (bus.data[BASE +: ROW_W]),
      .row_hit  (row_hit_c[r])
    );
  end

  // S1 may refill while S2 drains, so in_ready only drops with both stages full and stalled.
  assign s2_adv       = ~s2_valid | bus.out_ready;
  assign bus.in_ready = ~s1_valid | s2_adv;
  assign in_acc       = bus.in_valid & bus.in_ready;
  assign hit          = |s1_q.row_hit;

  always_comb begin
    s1_d                    = '0;
    s1_d.row_hit[N_ROW-1:0] = row_hit_c;
    s1_d.sel                = bus.sel;
    s1_d.a                  = bus.a;
    s1_d.b0                 = bus.b0;
    s1_d.b1                 = bus.b1;
    s1_d.dflt               = bus.dflt;
    s1_d.aux_en             = bus.aux_en;
    s1_d.aux_n              = bus.aux_n;
    s1_d.aux2_n             = bus.aux2_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_q     <= '0;
      f0_q     <= 1'b0;
      f1_q     <= 1'b0;
      f2_q     <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (bus.in_ready) s1_valid <= bus.in_valid;
      if (in_acc)       s1_q     <= s1_d;
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          f0_q <= s1_q.sel ? ~s1_q.a
                           : ((~s1_q.b0 & ~s1_q.b1) ? ~s1_q.dflt : ~hit);
          f1_q <= s1_q.sel | s1_q.b0 | (s1_q.aux_en & (s1_q.b1 | ~s1_q.aux_n));
          f2_q <= ~s1_q.b1 & (s1_q.sel | s1_q.b0 | ~s1_q.aux2_n);
        end
      end
      if (s2_valid & bus.out_ready & ~&cnt_q) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.out_valid  = s2_valid;
  assign bus.f0         = f0_q;
  assign bus.f1         = f1_q;
  assign bus.f2         = f2_q;
  assign bus.eval_count = cnt_q;

endmodule
